// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: arbitrates NREQ requesters onto a bank of WIDTH JK flip-flops, one command per 2 cycles.
// Define JK_SEQ_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module jk_bank_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge clk) begin
        if (rst) q <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end
endmodule

module jk_bank_sequencer #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [2*NREQ-1:0]      req_op,
    input  logic [IDXW*NREQ-1:0]   req_idx,
    output logic [NREQ-1:0]        req_ready,
    output logic [WIDTH-1:0]       q,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             done_id,
    output logic                   err
);
    typedef enum logic {IDLE, APPLY} state_t;

    state_t            state, state_nx;
    logic [1:0]        op_q, sel_op;
    logic [IDXW-1:0]   idx_q, sel_idx;
    logic [2:0]        gid_q, gnt;
    logic              gnt_vld, accept, oor;
    logic [WIDTH-1:0]  j, k;

`ifdef JK_SEQ_PRIORITY_EN
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int i = NREQ-1; i >= 0; i--)
            if (req_valid[i]) begin gnt_vld = 1'b1; gnt = 3'(i); end
    end
`else
    logic [2:0]      last_grant, rr_base;
    logic [NREQ-1:0] rot;

    // rotate valids so the search always starts at bit 0, then map the winner back
    always_comb begin
        rr_base = (last_grant == 3'(NREQ-1)) ? 3'd0 : last_grant + 3'd1;
        rot     = NREQ'({req_valid, req_valid} >> rr_base);
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int i = NREQ-1; i >= 0; i--)
            if (rot[i]) begin gnt_vld = 1'b1; gnt = 3'((int'(rr_base) + i) % NREQ); end
    end

    always_ff @(posedge clk) begin
        if (rst)         last_grant <= 3'(NREQ-1);
        else if (accept) last_grant <= gnt;
    end
`endif

    always_comb begin
        sel_op  = '0;
        sel_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt == 3'(i)) begin
                sel_op  = req_op[2*i +: 2];
                sel_idx = req_idx[IDXW*i +: IDXW];
            end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        case (state)
            IDLE: if (gnt_vld) begin
                req_ready = {{(NREQ-1){1'b0}}, 1'b1} << gnt;
                state_nx  = APPLY;
            end
            APPLY:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && gnt_vld;
    assign busy   = (state == APPLY);
    assign oor    = {1'b0, idx_q} >= (IDXW+1)'(WIDTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= '0;
            idx_q <= '0;
            gid_q <= '0;
        end else if (accept) begin
            op_q  <= sel_op;
            idx_q <= sel_idx;
            gid_q <= gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done    <= 1'b0;
            done_id <= '0;
            err     <= 1'b0;
        end else begin
            done <= busy;
            err  <= busy && oor;
            if (busy) done_id <= gid_q;
        end
    end

    // an out-of-range idx matches no cell, so the bank is left untouched
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        assign j[b] = busy && (idx_q == IDXW'(b)) && op_q[1];
        assign k[b] = busy && (idx_q == IDXW'(b)) && op_q[0];
        jk_bank_cell u_cell (.clk(clk), .rst(rst), .j(j[b]), .k(k[b]), .q(q[b]));
    end
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: directed scenarios plus random traffic against a transaction-level model.
module tb_jk_bank_sequencer;
    localparam int NREQ = 4, WIDTH = 8, IDXW = 4;

    logic                 clk = 1'b0, rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [2*NREQ-1:0]    req_op = '0;
    logic [IDXW*NREQ-1:0] req_idx = '0;
    logic [NREQ-1:0]      req_ready;
    logic [WIDTH-1:0]     q;
    logic                 busy, done, err;
    logic [2:0]           done_id;

    jk_bank_sequencer #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
        .req_ready(req_ready), .q(q), .busy(busy), .done(done), .done_id(done_id), .err(err)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0;
    // model: pending command, bank contents, last winner, registered completion flags
    logic             m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
    int               m_op = 0, m_idx = 0, m_id = 0, m_did = 0, m_last = NREQ-1;
    logic [WIDTH-1:0] mq = '0;
    int               acc = -1;
    int               grants[$];
    int               exp_ord [5];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int last);
`ifdef JK_SEQ_PRIORITY_EN
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        if (last < 0) return -1;
`else
        for (int o = 1; o <= NREQ; o++) if (v[(last + o) % NREQ]) return (last + o) % NREQ;
`endif
        return -1;
    endfunction

    task automatic set_req(input int i, input int op, input int idx);
        req_valid[i]           = 1'b1;
        req_op[2*i +: 2]       = 2'(op);
        req_idx[IDXW*i +: IDXW] = IDXW'(idx);
    endtask

    // one clock: compare at negedge, advance model on posedge, return #1 after the edge
    task automatic step();
        int g;
        @(negedge clk);
        g = m_busy ? -1 : pick(req_valid, m_last);
        if (!rst) chk("ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("q", 32'(q), 32'(mq));
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
        if (m_done) chk("done_id", 32'(done_id), 32'(m_did));
        @(posedge clk);
        acc = -1;
        if (rst) begin
            m_busy = 0; m_done = 0; m_err = 0; m_did = 0; m_last = NREQ-1; mq = '0;
        end else begin
            m_done = 0; m_err = 0;
            if (m_busy) begin
                if (m_idx < WIDTH) begin
                    case (m_op)
                        1: mq[m_idx] = 1'b0;
                        2: mq[m_idx] = 1'b1;
                        3: mq[m_idx] = ~mq[m_idx];
                        default: ;
                    endcase
                end
                m_done = 1; m_did = m_id; m_err = (m_idx >= WIDTH); m_busy = 0;
            end else if (g >= 0) begin
                m_busy = 1; m_id = g; m_last = g; acc = g;
                m_op  = int'(req_op[2*g +: 2]);
                m_idx = int'(req_idx[IDXW*g +: IDXW]);
            end
        end
        #1;
    endtask

    initial begin
        int jk_ops [5];
        logic jk_exp [5];
        jk_ops = '{2, 0, 3, 1, 3};
        jk_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef JK_SEQ_PRIORITY_EN
        exp_ord = '{0, 0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 2, 3, 0};
`endif
        // reset then idle
        step(); step();
        rst = 1'b0;
        repeat (5) step();
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_done_id", 32'(done_id), 32'h0);

        // single set from requester 2
        set_req(2, 2, 5);
        step();
        chk("set_acc", 32'(acc), 32'd2);
        req_valid = '0;
        step();
        chk("set_q", 32'(q), 32'h20);
        chk("set_done", 32'(done), 32'd1);
        chk("set_done_id", 32'(done_id), 32'd2);
        step();

        // contention: all requesters toggle their own bit
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 3, i);
        grants.delete();
        for (int c = 0; c < 10; c++) begin
            step();
            if (acc >= 0) grants.push_back(acc);
`ifdef JK_SEQ_PRIORITY_EN
            if (c == 7) chk("cont_q", 32'(q), 32'h00);
`else
            if (c == 7) chk("cont_q", 32'(q), 32'h0F);
`endif
        end
        chk("cont_cnt", 32'(grants.size()), 32'd5);
        for (int k = 0; k < 5 && k < grants.size(); k++) chk("cont_order", 32'(grants[k]), 32'(exp_ord[k]));
        req_valid = '0;
        step();

        // JK semantics on bit 0
        rst = 1'b1; step(); rst = 1'b0;
        for (int s = 0; s < 5; s++) begin
            set_req(0, jk_ops[s], 0);
            step();
            req_valid = '0;
            step();
            chk("jk_q0", 32'(q[0]), 32'(jk_exp[s]));
        end
        step();

        // out-of-range index
        set_req(1, 2, 9);
        step();
        chk("oor_acc", 32'(acc), 32'd1);
        req_valid = '0;
        step();
        chk("oor_q", 32'(q), 32'h01);
        chk("oor_done", 32'(done), 32'd1);
        chk("oor_err", 32'(err), 32'd1);
        step();

        // reset while applying discards the command
        set_req(3, 2, 3);
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("midrst_q", 32'(q), 32'h0);
        chk("midrst_done", 32'(done), 32'd0);
        set_req(3, 2, 3);
        set_req(0, 2, 1);
        step();
        chk("midrst_gnt", 32'(acc), 32'd0);
        req_valid = '0;
        step(); step();

        // random traffic, including withdrawals and resets at arbitrary points
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (rst) req_valid = '0;
            else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (acc == i) req_valid[i] = 1'b0;
                    else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                    else if (!req_valid[i] && $urandom_range(0, 2) == 0)
                        set_req(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
                end
            end
            step();
        end
        rst = 1'b0;
        req_valid = '0;
        step(); step(); step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/jk_bank_sequencer.md
# jk_bank_sequencer

Shared-resource controller for a bank of WIDTH JK flip-flops. Up to NREQ requesters issue per-bit JK commands (hold/reset/set/toggle) over valid/ready handshakes. The block arbitrates between them, sequences one command at a time onto the bank's J/K inputs, and reports completion. It is the single owner of the JK bank; requesters never drive J/K directly.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, JK flip-flops in the bank (1..16)
- IDXW, 4, bit-index width per requester; must satisfy 2^IDXW >= WIDTH
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  per-requester command valid
- req_op  input  2*NREQ  per-requester op, requester i at [2i+1:2i]
  - 00 hold (J=0,K=0)
  - 01 reset (J=0,K=1)
  - 10 set (J=1,K=0)
  - 11 toggle (J=1,K=1)
- req_idx  input  IDXW*NREQ  per-requester target bit, requester i at [IDXW*i+IDXW-1:IDXW*i]
- req_ready  output  NREQ  one-hot accept strobe
- q  output  WIDTH  JK bank state
- busy  output  1  high while a command is being applied
- done  output  1  one-cycle pulse when a command completes
- done_id  output  3  requester index of the completed command
- err  output  1  one-cycle pulse with done when the completed command had req_idx >= WIDTH

## Operation
- FSM states: IDLE, APPLY.
- IDLE:
  - If any req_valid is set, grant exactly one requester g and drive req_ready[g]=1 combinationally in the same cycle.
  - Handshake completes on that edge: latch op, idx and g, then go to APPLY.
  - If no req_valid is set, stay in IDLE with req_ready all zero.
- APPLY:
  - busy=1, req_ready=0.
  - The latched op drives J/K of bit idx only. All other bits see J=K=0.
  - On the edge leaving APPLY, q[idx] updates per JK rules: 00 keep, 01→0, 10→1, 11→~q[idx].
  - Return to IDLE.
- Arbitration: round-robin. Search starts at last_grant+1 modulo NREQ. After reset last_grant=NREQ-1, so requester 0 has top priority first.
- req_ready depends on req_valid. A requester must hold valid, op and idx stable until it sees ready.
- Out-of-range idx (>= WIDTH): the command is accepted and sequenced normally, but q is unchanged and err pulses with done.
- Hold op: completes normally with done. q is unchanged and err=0.

## Timing
- Reset values: q=0, busy=0, done=0, done_id=0, err=0, req_ready=0, state=IDLE, last_grant=NREQ-1.
- Accept edge N (req_valid[g] & req_ready[g]). Edge N+1 updates q. done/done_id/err are registered high during the cycle after edge N+1.
- Throughput is one command per 2 cycles. The next grant can occur in the IDLE cycle in which done is high.
- Simultaneous valids: only the round-robin winner gets ready. Losers wait with valid held.
- Requester deasserts valid before ready: no command is recorded and no side effect occurs.
- rst asserted in any state, including APPLY: the next edge forces all reset values. The latched command is discarded and no done is produced.
- Back-to-back toggles on the same bit from different requesters alternate q each command.

## Configuration
- JK_SEQ_PRIORITY_EN defined: fixed priority replaces round-robin. The lowest valid index always wins and last_grant is unused. Starvation of high indices is permitted.
- Not defined: round-robin as specified above.

## Test plan
- Reset then idle: hold rst=1 for 2 cycles with valid=0 → q=0x00, busy=0, done=0, and all zero for 5 further cycles.
- Single set: req 2 op=10 idx=5 → ready[2] on accept edge, q=0x20 one edge later, done=1 with done_id=2 and err=0.
- Contention: all 4 requesters valid continuously, each toggling bit i → grants in order 0,1,2,3,0. After 4 commands q=0x0F. With JK_SEQ_PRIORITY_EN, grants are 0,0,0,…
- JK semantics on bit 0: sequence set, hold, toggle, reset, toggle → q[0]=1,1,0,0,1.
- Out-of-range: WIDTH=6, idx=7, op=10 → accepted, q unchanged, done=1 with err=1.
- Reset mid-APPLY: accept set idx=3, assert rst on the following cycle → q=0x00, no done pulse, and the next command is granted to requester 0.
